// File: rtl/i2s_pkg.sv
// Shared types, defaults and helpers for the I2S master-mode blocks.
package i2s_pkg;

    localparam int I2S_WIDTH   = 16;
    localparam int I2S_CLK_DIV = 4;

    // One stereo PCM pair at the default slot width.
    typedef struct packed {
        logic [I2S_WIDTH-1:0] left;
        logic [I2S_WIDTH-1:0] right;
    } stereo_sample_t;

    // Word-select level for slot s: high from the last left bit up to the
    // second-to-last right bit, so ws always leads a channel's MSB by one SCK.
    function automatic logic ws_for_slot(input int s, input int width);
        return (s >= width - 1) && (s <= 2 * width - 2);
    endfunction

endpackage

// File: rtl/i2s_sck_gen.sv
// Bit-clock generator: divides clk into a 50% duty SCK and flags the clk
// cycle on which SCK is about to rise or fall.
module i2s_sck_gen
    import i2s_pkg::*;
#(
    parameter int CLK_DIV = I2S_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    output logic sck,
    output logic fall,
    output logic rise
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div;
    logic          terminal;

    assign terminal = (div == DIV_LAST);
    // Strobes are valid in the cycle whose clock edge moves sck.
    assign fall     = terminal & sck;
    assign rise     = terminal & ~sck;

    // Half-period counter; sck flips each time the counter wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            div <= '0;
            sck <= 1'b0;
        end else if (terminal) begin
            div <= '0;
            sck <= ~sck;
        end else begin
            div <= div + 1'b1;
        end
    end

endmodule

// File: rtl/i2s_transmitter.sv
// I2S master transmitter: standard I2S framing, MSB first, one-SCK data
// delay after each WS edge, WS low = left. Far end samples SD on rising SCK.
//
// Input handshake: a pair is transferred on a clk edge where in_valid and
// in_ready are both high; in_ready is high whenever the one-entry holding
// register is empty. in_left/in_right are only sampled on that transfer.
module i2s_transmitter
    import i2s_pkg::*;
#(
    parameter int WIDTH   = I2S_WIDTH,
    parameter int CLK_DIV = I2S_CLK_DIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_left,
    input  logic [WIDTH-1:0] in_right,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sck,
    output logic             ws,
    output logic             sd,
    output logic             frame_start,
    output logic             underrun
);

    localparam int SLOTS = 2 * WIDTH;
    localparam int SW    = $clog2(SLOTS);
    localparam logic [SW-1:0] LAST_SLOT = SW'(SLOTS - 1);

    typedef struct packed {
        logic [WIDTH-1:0] left;
        logic [WIDTH-1:0] right;
    } pair_t;

    logic             fall;
    logic             sck_rise_unused;
    logic [SW-1:0]    slot;
    logic [SW-1:0]    slot_next;
    logic [SLOTS-1:0] shift;
    pair_t            hold;
    logic             full;
    logic             accept;

    i2s_sck_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sck_gen (
        .clk  (clk),
        .reset(reset),
        .sck  (sck),
        .fall (fall),
        .rise (sck_rise_unused)
    );

    assign in_ready  = ~full;
    assign accept    = in_valid & ~full;
    assign slot_next = (slot == LAST_SLOT) ? '0 : slot + 1'b1;

    // Holding register, slot counter and serializer; ws/sd move with the fall.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot        <= LAST_SLOT;
            ws          <= 1'b0;
            sd          <= 1'b0;
            shift       <= '0;
            hold        <= '0;
            full        <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            // An accept can only happen while empty, so it never collides
            // with the load below draining a full register.
            if (accept) begin
                hold <= '{left: in_left, right: in_right};
                full <= 1'b1;
            end
            if (fall) begin
                slot <= slot_next;
                ws   <= ws_for_slot(int'(slot_next), WIDTH);
                if (slot_next == '0) begin
                    frame_start <= 1'b1;
                    if (full) begin
                        shift <= hold;
                        sd    <= hold.left[WIDTH-1];
                        full  <= 1'b0;
                    end else begin
                        // Nothing to send: emit digital silence this frame.
                        shift    <= '0;
                        sd       <= 1'b0;
                        underrun <= 1'b1;
                    end
                end else begin
                    shift <= {shift[SLOTS-2:0], 1'b0};
                    sd    <= shift[SLOTS-2];
                end
            end
        end
    end

endmodule

// File: doc/i2s_transmitter.md
Name: i2s_transmitter

Overview:
- Serializes stereo PCM samples onto an I2S link and generates SCK and WS from the fabric clock.
- Acts as the link master: the far end, whether codec DAC or FPGA receiver, only samples SD on rising SCK.
- Sits between the processing pipeline's stereo output stream (valid/ready) and the codec pins.
- Frame format: standard I2S, MSB first, one-SCK data delay after each WS edge, WS low = left channel.

Parameters:
- WIDTH, 16, bits per channel slot; frame = 2*WIDTH SCK periods.
- CLK_DIV, 4, clk cycles per SCK half-period (>=1); SCK period = 2*CLK_DIV clk.

Ports:
- clk  in  1  fabric clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- in_left  in  WIDTH  left sample, two's complement.
- in_right  in  WIDTH  right sample.
- in_valid  in  1  sample pair valid.
- in_ready  out  1  holding register empty; pair accepted when in_valid && in_ready.
- sck  out  1  I2S bit clock, registered.
- ws  out  1  I2S word select, registered.
- sd  out  1  I2S serial data, registered.
- frame_start  out  1  one-clk pulse when a new frame loads (slot 0).
- underrun  out  1  one-clk pulse when a frame loads with no sample held.

Behaviour:
- Clock divider: counter div 0..CLK_DIV-1. At terminal count, sck toggles and div returns to 0.
- fall strobe = terminal count while sck==1. rise strobe = terminal count while sck==0.
- Slot counter s, 0..2*WIDTH-1, advances on each fall strobe and wraps 2*WIDTH-1 -> 0.
- All sck/ws/sd updates happen in the same clk cycle as the fall strobe, so they change together on the SCK falling edge.
- ws after fall into slot s: 1 when WIDTH-1 <= s <= 2*WIDTH-2, else 0.
- ws therefore leads the channel's MSB by one SCK.
- sd in slot s:
  - left[WIDTH-1-s] for s < WIDTH;
  - right[2*WIDTH-1-s] for s >= WIDTH.
  - sd comes from a 2*WIDTH shift register loaded {left,right} and shifted left on each fall.
- Load at the fall into s=0:
  - Holding register full: shift register <= holding contents, holding empties, frame_start=1.
  - Holding register empty: shift register <= 0, frame_start=1, underrun=1.
- Holding register: single entry, in_ready = !full.
  - Accept sets full. If accept and load occur in the same cycle, the load sees empty (underrun) and the accept still fills the holding register.
- Latency: an accepted pair begins at the next frame boundary. Its left MSB is on sd from that fall until the following fall.
- Reset values: sck=0, ws=0, sd=0, div=0, s=2*WIDTH-1, shift=0, holding empty, in_ready=1, frame_start=0, underrun=0.
- First fall after reset is at clk 2*CLK_DIV and loads slot 0.
- Reset mid-frame: an immediate return to the reset state; the partial frame is abandoned and the held sample is discarded.
- in_left/in_right are sampled only on accept; changes while full are ignored.

Decomposition:
- Package i2s_pkg:
  - localparam defaults (I2S_WIDTH=16, I2S_CLK_DIV=4).
  - typedef stereo_sample_t (struct: left, right, each logic [WIDTH-1:0]).
  - function ws_for_slot(s, width).
- Sub-module i2s_sck_gen: divider plus sck register, emitting fall/rise strobes. It is reusable by future master-mode blocks.

Test Plan (WIDTH=16, CLK_DIV=2: SCK period 4 clk, frame 128 clk):
- Reset released, no input -> sck toggles every 2 clk; first fall at clk 4 with frame_start=1 and underrun=1; sd=0 for the whole frame; ws low for slots 0..14, high for 15..30, low at 31.
- Accept left=0xA5C3, right=0x1234 before the first frame -> in_ready drops for 1 frame; on rising SCK, sd reads bits A5C3 MSB-first in slots 0..15, then 1234 in slots 16..31; underrun=0.
- Loopback through an I2S receiver model, streaming 0x8000/0x7FFF, 0x0001/0xFFFF, 0x0000/0x5555 back-to-back with in_valid held high -> all three pairs recovered in order; no underrun after the first frame.
- in_valid asserted on the exact frame-load cycle with the holding register empty -> underrun pulses for that frame; the pair is transmitted in the next frame.
- Assert reset at slot 20 mid-frame -> next clk: sck=ws=sd=0, in_ready=1; restart matches scenario 1 timing.
- CLK_DIV=1 -> SCK period 2 clk; 0xFFFF/0x0000 frame is serialized correctly; ws edge one SCK before each MSB.
